vc_mux_n_reg_sd: RTL and testbench

// - Registered N-input, same-domain mux with valid/ready handshake. Successor to the

---
 rtl/vc_mux_n_reg_sd.sv | 112 +++++++++++
 tb/tb_vc_mux_n_reg_sd.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vc_mux_n_reg_sd.sv
// Registered N-input same-domain mux with valid/ready handshake and 1-cycle latency.
// Optional macro VC_MUX_N_REG_SD_SCRUB_EN inserts an idle bubble at each domain change.
module vc_mux_n_reg_sd #(
  parameter int unsigned p_nbits   = 32,
  parameter int unsigned p_ninputs = 4,
  localparam int unsigned c_selbits = $clog2(p_ninputs)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_val,
  output logic                           in_rdy,
  input  logic [p_ninputs*p_nbits-1:0]   in_data,
  input  logic [c_selbits-1:0]           sel,
  input  logic [1:0]                     domain,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [p_nbits-1:0]             out_data,
  output logic [1:0]                     out_domain,
  output logic                           out_err
);

`ifdef VC_MUX_N_REG_SD_SCRUB_EN
  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SCRUB} state_e;
`else
  typedef enum logic {S_EMPTY, S_FULL} state_e;
`endif

  state_e             state_q, state_d;
  logic [p_nbits-1:0] data_q, data_d;
  logic [1:0]         domain_q, domain_d;
  logic               err_q, err_d;
  logic [1:0]         last_domain_q, last_domain_d;

  logic [p_nbits-1:0] lane;
  logic               sel_ok;
  logic               load;
  state_e             load_state;

  // Lane pick by comparison loop so a non-power-of-two lane count never indexes past in_data.
  always_comb begin
    lane   = '0;
    sel_ok = (32'(sel) < p_ninputs);
    for (int unsigned i = 0; i < p_ninputs; i++) begin
      if (32'(sel) == i) lane = in_data[i*p_nbits +: p_nbits];
    end
  end

  always_comb begin
    in_rdy  = (state_q == S_EMPTY) || ((state_q == S_FULL) && out_rdy);
    out_val = (state_q == S_FULL);
    load    = in_val && in_rdy;

`ifdef VC_MUX_N_REG_SD_SCRUB_EN
    load_state = (domain != last_domain_q) ? S_SCRUB : S_FULL;
`else
    load_state = S_FULL;
`endif

    state_d = state_q;
    case (state_q)
      S_EMPTY: if (load) state_d = load_state;
      S_FULL: begin
        if (load)         state_d = load_state;
        else if (out_rdy) state_d = S_EMPTY;
      end
`ifdef VC_MUX_N_REG_SD_SCRUB_EN
      S_SCRUB: state_d = S_FULL;
`endif
      default: state_d = S_EMPTY;
    endcase

    data_d        = data_q;
    domain_d      = domain_q;
    err_d         = err_q;
    last_domain_d = last_domain_q;
    if (load) begin
      data_d        = sel_ok ? lane : '0;
      domain_d      = domain;
      err_d         = !sel_ok;
      last_domain_d = domain;
    end
  end

`ifndef VC_MUX_N_REG_SD_SCRUB_EN
  logic unused_last_domain;
  assign unused_last_domain = ^last_domain_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_EMPTY;
      data_q        <= '0;
      domain_q      <= '0;
      err_q         <= 1'b0;
      last_domain_q <= '0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      domain_q      <= domain_d;
      err_q         <= err_d;
      last_domain_q <= last_domain_d;
    end
  end

  // Held register stays intact while idle; only the visible outputs are forced to zero.
  always_comb begin
    out_data   = out_val ? data_q   : '0;
    out_domain = out_val ? domain_q : '0;
    out_err    = out_val ? err_q    : 1'b0;
  end

endmodule

// File: tb/tb_vc_mux_n_reg_sd.sv
// Directed self-checking bench for vc_mux_n_reg_sd with 3 lanes of 8 bits.
module tb_vc_mux_n_reg_sd;

  logic        clk;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [23:0] in_data;
  logic [1:0]  sel;
  logic [1:0]  domain;
  logic        out_val;
  logic        out_rdy;
  logic [7:0]  out_data;
  logic [1:0]  out_domain;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  vc_mux_n_reg_sd #(.p_nbits(8), .p_ninputs(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_data    (in_data),
    .sel        (sel),
    .domain     (domain),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .out_domain (out_domain),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_val = 1'b0; out_rdy = 1'b0; sel = '0; domain = '0;
    in_data = 24'h332211;
    step(); step();
    total++; if (out_val !== 1'b0)  begin bad++; $display("FAIL reset_out_val got=%b exp=0", out_val); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    total++; if (out_domain !== 2'd0) begin bad++; $display("FAIL reset_out_domain got=%0d exp=0", out_domain); end
    total++; if (out_err !== 1'b0)  begin bad++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    reset = 1'b0;
    step();
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL reset_in_rdy got=%b exp=1", in_rdy); end
  endtask

  task automatic test_single();
    in_val = 1'b1; sel = 2'd1; domain = 2'd0; out_rdy = 1'b1;
    step();
    in_val = 1'b0;
    total++; if (out_val !== 1'b1)   begin bad++; $display("FAIL single_out_val got=%b exp=1", out_val); end
    total++; if (out_data !== 8'h22) begin bad++; $display("FAIL single_out_data got=%h exp=22", out_data); end
    total++; if (out_domain !== 2'd0) begin bad++; $display("FAIL single_out_domain got=%0d exp=0", out_domain); end
    total++; if (out_err !== 1'b0)   begin bad++; $display("FAIL single_out_err got=%b exp=0", out_err); end
    step();
    total++; if (out_val !== 1'b0)   begin bad++; $display("FAIL drain_out_val got=%b exp=0", out_val); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL drain_out_data_gated got=%h exp=00", out_data); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] sels [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [7:0] exps [4] = '{8'h11, 8'h22, 8'h33, 8'h11};
    out_rdy = 1'b1; domain = 2'd0;
    for (int k = 0; k < 4; k++) begin
      in_val = 1'b1; sel = sels[k];
      #1;
      total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL stream_in_rdy[%0d] got=%b exp=1", k, in_rdy); end
      step();
      total++; if (out_val !== 1'b1) begin bad++; $display("FAIL stream_out_val[%0d] got=%b exp=1", k, out_val); end
      total++; if (out_data !== exps[k]) begin bad++; $display("FAIL stream_out_data[%0d] got=%h exp=%h", k, out_data, exps[k]); end
    end
    in_val = 1'b0;
    step();
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_val); end
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0; in_val = 1'b1; sel = 2'd2; domain = 2'd0;
    #1;
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL bp_in_rdy_empty got=%b exp=1", in_rdy); end
    step();
    total++; if (out_val !== 1'b1)   begin bad++; $display("FAIL bp_out_val got=%b exp=1", out_val); end
    total++; if (out_data !== 8'h33) begin bad++; $display("FAIL bp_out_data got=%h exp=33", out_data); end
    total++; if (in_rdy !== 1'b0)    begin bad++; $display("FAIL bp_in_rdy_full got=%b exp=0", in_rdy); end
    sel = 2'd0; domain = 2'd1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (out_val !== 1'b1)    begin bad++; $display("FAIL bp_hold_val[%0d] got=%b exp=1", k, out_val); end
      total++; if (out_data !== 8'h33)  begin bad++; $display("FAIL bp_hold_data[%0d] got=%h exp=33", k, out_data); end
      total++; if (out_domain !== 2'd0) begin bad++; $display("FAIL bp_hold_domain[%0d] got=%0d exp=0", k, out_domain); end
    end
    out_rdy = 1'b1; domain = 2'd0;
    #1;
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL bp_release_in_rdy got=%b exp=1", in_rdy); end
    step();
    total++; if (out_data !== 8'h11) begin bad++; $display("FAIL bp_reload_data got=%h exp=11", out_data); end
    in_val = 1'b0;
    step();
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_val); end
  endtask

  task automatic test_out_of_range();
    out_rdy = 1'b1; in_val = 1'b1; sel = 2'd3; domain = 2'd0;
    step();
    total++; if (out_val !== 1'b1)   begin bad++; $display("FAIL oor_out_val got=%b exp=1", out_val); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL oor_out_data got=%h exp=00", out_data); end
    total++; if (out_err !== 1'b1)   begin bad++; $display("FAIL oor_out_err got=%b exp=1", out_err); end
    sel = 2'd0;
    step();
    total++; if (out_data !== 8'h11) begin bad++; $display("FAIL oor_next_data got=%h exp=11", out_data); end
    total++; if (out_err !== 1'b0)   begin bad++; $display("FAIL oor_next_err got=%b exp=0", out_err); end
    in_val = 1'b0;
    step();
  endtask

  task automatic test_domain_change();
    out_rdy = 1'b1; in_val = 1'b1; sel = 2'd0; domain = 2'd0;
    step();
    total++; if (out_data !== 8'h11) begin bad++; $display("FAIL dom_first_data got=%h exp=11", out_data); end
    sel = 2'd1; domain = 2'd1;
    step();
    in_val = 1'b0;
`ifdef VC_MUX_N_REG_SD_SCRUB_EN
    #1;
    total++; if (out_val !== 1'b0)   begin bad++; $display("FAIL scrub_out_val got=%b exp=0", out_val); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL scrub_out_data got=%h exp=00", out_data); end
    total++; if (in_rdy !== 1'b0)    begin bad++; $display("FAIL scrub_in_rdy got=%b exp=0", in_rdy); end
    step();
`endif
    total++; if (out_val !== 1'b1)    begin bad++; $display("FAIL dom_second_val got=%b exp=1", out_val); end
    total++; if (out_data !== 8'h22)  begin bad++; $display("FAIL dom_second_data got=%h exp=22", out_data); end
    total++; if (out_domain !== 2'd1) begin bad++; $display("FAIL dom_second_domain got=%0d exp=1", out_domain); end
    step();
  endtask

  task automatic test_async_reset();
    out_rdy = 1'b0; in_val = 1'b1; sel = 2'd2; domain = 2'd1;
    step();
`ifdef VC_MUX_N_REG_SD_SCRUB_EN
    if (out_val !== 1'b1) step();
`endif
    in_val = 1'b0;
    total++; if (out_data !== 8'h33)  begin bad++; $display("FAIL ar_loaded_data got=%h exp=33", out_data); end
    total++; if (out_domain !== 2'd1) begin bad++; $display("FAIL ar_loaded_domain got=%0d exp=1", out_domain); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (out_val !== 1'b0)    begin bad++; $display("FAIL ar_out_val got=%b exp=0", out_val); end
    total++; if (out_data !== 8'h00)  begin bad++; $display("FAIL ar_out_data got=%h exp=00", out_data); end
    total++; if (out_domain !== 2'd0) begin bad++; $display("FAIL ar_out_domain got=%0d exp=0", out_domain); end
    step();
    reset = 1'b0; out_rdy = 1'b1;
    step();
    total++; if (in_rdy !== 1'b1)  begin bad++; $display("FAIL ar_post_in_rdy got=%b exp=1", in_rdy); end
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL ar_post_out_val got=%b exp=0", out_val); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_domain_change();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
